// File: rtl/core_pkg.sv
// core_pkg: types shared by the segmented RISC-V pipeline stages.
// Contents: forwarding select codes, ID/EX stage states, control bundle + BUBBLE.
package core_pkg;

    // ALU operand mux select: register data, WB mux result,
    // EX/MEM register result, or zero/immediate alternative.
    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_WB  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_ALT = 2'd3
    } fwd_sel_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        STALLED = 1'b1
    } stage_state_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{
        valid:      1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0
    };

endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: Decode-side inputs and Execute-side outputs of the ID/EX register.
// Ports: id_* decoded instruction, mem_* EX/MEM producer, flush; stall, ex_*, counters out.
interface id_ex_stage_if #(
    parameter int data_bits     = 32,
    parameter int reg_addr_bits = 5,
    parameter int alu_op_bits   = 4,
    parameter int count_bits    = 32
);
    logic                     id_valid;
    logic [reg_addr_bits-1:0] id_rs1_addr;
    logic [reg_addr_bits-1:0] id_rs2_addr;
    logic [reg_addr_bits-1:0] id_rd_addr;
    logic [data_bits-1:0]     id_rs1_data;
    logic [data_bits-1:0]     id_rs2_data;
    logic [data_bits-1:0]     id_immediate;
    logic [alu_op_bits-1:0]   id_alu_operation;
    logic                     id_alu_src_imm;
    logic                     id_op1_zero;
    logic                     id_reg_write;
    logic                     id_mem_read;
    logic                     id_mem_write;
    logic                     id_mem_to_reg;
    logic [reg_addr_bits-1:0] mem_rd_addr;
    logic                     mem_reg_write;
    logic                     flush;

    logic                     stall;
    logic                     ex_valid;
    logic [data_bits-1:0]     ex_rs1_data;
    logic [data_bits-1:0]     ex_rs2_data;
    logic [data_bits-1:0]     ex_immediate;
    logic [reg_addr_bits-1:0] ex_rd_addr;
    logic [alu_op_bits-1:0]   ex_alu_operation;
    logic [1:0]               ex_fwd_sel_1;
    logic [1:0]               ex_fwd_sel_2;
    logic [1:0]               ex_store_fwd_sel;
    logic                     ex_reg_write;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_mem_to_reg;
    logic [count_bits-1:0]    stall_count;
    logic [count_bits-1:0]    flush_count;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_rs1_data, id_rs2_data, id_immediate, id_alu_operation,
        output id_alu_src_imm, id_op1_zero,
        output id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        output mem_rd_addr, mem_reg_write, flush,
        input  stall, ex_valid, ex_rs1_data, ex_rs2_data, ex_immediate,
        input  ex_rd_addr, ex_alu_operation,
        input  ex_fwd_sel_1, ex_fwd_sel_2, ex_store_fwd_sel,
        input  ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        input  stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_rs1_data, id_rs2_data, id_immediate, id_alu_operation,
        input  id_alu_src_imm, id_op1_zero,
        input  id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
        input  mem_rd_addr, mem_reg_write, flush,
        output stall, ex_valid, ex_rs1_data, ex_rs2_data, ex_immediate,
        output ex_rd_addr, ex_alu_operation,
        output ex_fwd_sel_1, ex_fwd_sel_2, ex_store_fwd_sel,
        output ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
        output stall_count, flush_count
    );

endinterface

// File: rtl/forward_select.sv
// forward_select: picks the youngest in-flight producer of one source register.
// Ports: rs_addr; ex_rd_addr/ex_reg_write (EX); mem_rd_addr/mem_reg_write (MEM); sel out.
module forward_select
    import core_pkg::*;
#(
    parameter int reg_addr_bits = 5
) (
    input  logic [reg_addr_bits-1:0] rs_addr,
    input  logic [reg_addr_bits-1:0] ex_rd_addr,
    input  logic                     ex_reg_write,
    input  logic [reg_addr_bits-1:0] mem_rd_addr,
    input  logic                     mem_reg_write,
    output fwd_sel_t                 sel
);

    // The instruction entering EX next cycle sees today's EX producer
    // in EX/MEM, and today's MEM producer on the WB mux.
    always_comb begin
        sel = FWD_REG;
        if (rs_addr != '0) begin
            if (ex_reg_write && ex_rd_addr == rs_addr) begin
                sel = FWD_MEM;
            end else if (mem_reg_write && mem_rd_addr == rs_addr) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with early forwarding selects and load-use stall.
// Ports: clk, reset (async, active-high), bus (id_ex_stage_if.slave).
module id_ex_stage
    import core_pkg::*;
#(
    parameter int data_bits     = 32,
    parameter int reg_addr_bits = 5,
    parameter int alu_op_bits   = 4,
    parameter int count_bits    = 32
) (
    input  logic         clk,
    input  logic         reset,
    id_ex_stage_if.slave bus
);

    stage_state_t state_q;
    stage_state_t state_d;

    ctrl_t                    ex_ctrl_q;
    ctrl_t                    id_ctrl;
    logic [reg_addr_bits-1:0] ex_rd_q;
    logic [data_bits-1:0]     ex_rs1_q;
    logic [data_bits-1:0]     ex_rs2_q;
    logic [data_bits-1:0]     ex_imm_q;
    logic [alu_op_bits-1:0]   ex_op_q;
    fwd_sel_t                 sel_1_q;
    fwd_sel_t                 sel_2_q;
    fwd_sel_t                 store_sel_q;
    logic [count_bits-1:0]    stall_cnt_q;
    logic [count_bits-1:0]    flush_cnt_q;

    fwd_sel_t fwd_1;
    fwd_sel_t fwd_2;
    fwd_sel_t sel_1_d;
    fwd_sel_t sel_2_d;

    logic rs1_used;
    logic rs2_used;
    logic hazard;
    logic stall;
    logic insert_bubble;
    logic load_id;

    forward_select #(
        .reg_addr_bits(reg_addr_bits)
    ) u_fwd_1 (
        .rs_addr      (bus.id_rs1_addr),
        .ex_rd_addr   (ex_rd_q),
        .ex_reg_write (ex_ctrl_q.reg_write),
        .mem_rd_addr  (bus.mem_rd_addr),
        .mem_reg_write(bus.mem_reg_write),
        .sel          (fwd_1)
    );

    forward_select #(
        .reg_addr_bits(reg_addr_bits)
    ) u_fwd_2 (
        .rs_addr      (bus.id_rs2_addr),
        .ex_rd_addr   (ex_rd_q),
        .ex_reg_write (ex_ctrl_q.reg_write),
        .mem_rd_addr  (bus.mem_rd_addr),
        .mem_reg_write(bus.mem_reg_write),
        .sel          (fwd_2)
    );

    assign sel_1_d = bus.id_op1_zero    ? FWD_ALT : fwd_1;
    assign sel_2_d = bus.id_alu_src_imm ? FWD_ALT : fwd_2;

    // Stores read rs2 even when operand 2 is the immediate.
    assign rs1_used = !bus.id_op1_zero;
    assign rs2_used = !bus.id_alu_src_imm || bus.id_mem_write;

    assign hazard = ex_ctrl_q.valid && ex_ctrl_q.mem_read
                 && ex_rd_q != '0 && bus.id_valid
                 && ((rs1_used && ex_rd_q == bus.id_rs1_addr)
                  || (rs2_used && ex_rd_q == bus.id_rs2_addr));

    // Control is gated by id_valid so an empty Decode slot
    // cannot leak stray write enables into later stages.
    always_comb begin
        id_ctrl            = BUBBLE;
        id_ctrl.valid      = bus.id_valid;
        id_ctrl.reg_write  = bus.id_valid & bus.id_reg_write;
        id_ctrl.mem_read   = bus.id_valid & bus.id_mem_read;
        id_ctrl.mem_write  = bus.id_valid & bus.id_mem_write;
        id_ctrl.mem_to_reg = bus.id_valid & bus.id_mem_to_reg;
    end

    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        insert_bubble = 1'b0;
        load_id       = 1'b0;
        if (bus.flush) begin
            insert_bubble = 1'b1;
            state_d       = NORMAL;
        end else begin
            unique case (state_q)
                NORMAL: begin
                    if (hazard) begin
                        stall         = 1'b1;
                        insert_bubble = 1'b1;
                        state_d       = STALLED;
                    end else begin
                        load_id = 1'b1;
                        state_d = NORMAL;
                    end
                end
                STALLED: begin
                    // EX holds the bubble, so hazard is normally low here;
                    // it is still honoured rather than assumed away.
                    if (hazard) begin
                        stall         = 1'b1;
                        insert_bubble = 1'b1;
                        state_d       = STALLED;
                    end else begin
                        load_id = 1'b1;
                        state_d = NORMAL;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= NORMAL;
            ex_ctrl_q   <= BUBBLE;
            ex_rd_q     <= '0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_imm_q    <= '0;
            ex_op_q     <= '0;
            sel_1_q     <= FWD_REG;
            sel_2_q     <= FWD_REG;
            store_sel_q <= FWD_REG;
        end else begin
            state_q <= state_d;
            if (insert_bubble) begin
                // Data fields are left alone to avoid needless toggling.
                ex_ctrl_q <= BUBBLE;
                ex_rd_q   <= '0;
            end else if (load_id) begin
                ex_ctrl_q   <= id_ctrl;
                ex_rd_q     <= bus.id_valid ? bus.id_rd_addr : '0;
                ex_rs1_q    <= bus.id_rs1_data;
                ex_rs2_q    <= bus.id_rs2_data;
                ex_imm_q    <= bus.id_immediate;
                ex_op_q     <= bus.id_alu_operation;
                sel_1_q     <= sel_1_d;
                sel_2_q     <= sel_2_d;
                store_sel_q <= fwd_2;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (bus.flush && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall            = stall;
    assign bus.ex_valid         = ex_ctrl_q.valid;
    assign bus.ex_reg_write     = ex_ctrl_q.reg_write;
    assign bus.ex_mem_read      = ex_ctrl_q.mem_read;
    assign bus.ex_mem_write     = ex_ctrl_q.mem_write;
    assign bus.ex_mem_to_reg    = ex_ctrl_q.mem_to_reg;
    assign bus.ex_rd_addr       = ex_rd_q;
    assign bus.ex_rs1_data      = ex_rs1_q;
    assign bus.ex_rs2_data      = ex_rs2_q;
    assign bus.ex_immediate     = ex_imm_q;
    assign bus.ex_alu_operation = ex_op_q;
    assign bus.ex_fwd_sel_1     = sel_1_q;
    assign bus.ex_fwd_sel_2     = sel_2_q;
    assign bus.ex_store_fwd_sel = store_sel_q;
    assign bus.stall_count      = stall_cnt_q;
    assign bus.flush_count      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Table of pipeline scenarios, flush/reset sequences, then random vs. a pipeline model.
module tb_id_ex_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset;

    id_ex_stage_if bus ();

    id_ex_stage dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit        v;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [4:0]  rd;
        bit [31:0] d1;
        bit [31:0] d2;
        bit [31:0] imm;
        bit [3:0]  op;
        bit        simm;
        bit        z;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        m2r;
    } ins_t;

    typedef struct packed {
        bit        valid;
        bit [4:0]  rd;
        bit        rw;
        bit        mr;
        bit        mw;
        bit        m2r;
        bit [1:0]  s1;
        bit [1:0]  s2;
        bit [1:0]  st;
        bit [31:0] d1;
        bit [31:0] d2;
        bit [31:0] imm;
        bit [3:0]  op;
    } exp_t;

    typedef struct {
        ins_t     id;
        bit [4:0] mrd;
        bit       mrw;
        bit       fl;
        bit       e_stall;
        bit       e_valid;
        bit [1:0] e_s1;
        bit [1:0] e_s2;
        bit [1:0] e_st;
        bit [4:0] e_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic ins_t mk(bit v, bit [4:0] rs1, bit [4:0] rs2,
                                bit [4:0] rd, bit [31:0] imm, bit simm,
                                bit z, bit rw, bit mr, bit mw, bit m2r);
        ins_t i;
        i = '0;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.imm = imm; i.simm = simm; i.z = z;
        i.rw = rw; i.mr = mr; i.mw = mw; i.m2r = m2r;
        return i;
    endfunction

    function automatic vec_t row(ins_t id, bit [4:0] mrd, bit mrw, bit fl,
                                 bit st, bit ev, bit [1:0] s1, bit [1:0] s2,
                                 bit [1:0] sst, bit [4:0] erd);
        vec_t r;
        r.id = id; r.mrd = mrd; r.mrw = mrw; r.fl = fl;
        r.e_stall = st; r.e_valid = ev;
        r.e_s1 = s1; r.e_s2 = s2; r.e_st = sst; r.e_rd = erd;
        return r;
    endfunction

    // What EX should hold after latching instruction i with the given selects.
    function automatic exp_t latched(ins_t i, bit [1:0] s1, bit [1:0] s2,
                                     bit [1:0] st);
        exp_t e;
        e = '0;
        e.valid = i.v;
        e.rd = i.v ? i.rd : 5'd0;
        e.rw = i.v & i.rw; e.mr = i.v & i.mr;
        e.mw = i.v & i.mw; e.m2r = i.v & i.m2r;
        e.s1 = s1; e.s2 = s2; e.st = st;
        e.d1 = i.d1; e.d2 = i.d2; e.imm = i.imm; e.op = i.op;
        return e;
    endfunction

    task automatic drive(input ins_t i, input bit [4:0] mrd, input bit mrw,
                         input bit fl);
        bus.id_valid = i.v;
        bus.id_rs1_addr = i.rs1;
        bus.id_rs2_addr = i.rs2;
        bus.id_rd_addr = i.rd;
        bus.id_rs1_data = i.d1;
        bus.id_rs2_data = i.d2;
        bus.id_immediate = i.imm;
        bus.id_alu_operation = i.op;
        bus.id_alu_src_imm = i.simm;
        bus.id_op1_zero = i.z;
        bus.id_reg_write = i.rw;
        bus.id_mem_read = i.mr;
        bus.id_mem_write = i.mw;
        bus.id_mem_to_reg = i.m2r;
        bus.mem_rd_addr = mrd;
        bus.mem_reg_write = mrw;
        bus.flush = fl;
    endtask

    task automatic check_ex(input string tag, input exp_t e);
        check({tag, " ex_valid"}, 32'(bus.ex_valid), 32'(e.valid));
        check({tag, " ex_rd_addr"}, 32'(bus.ex_rd_addr), 32'(e.rd));
        check({tag, " ex_reg_write"}, 32'(bus.ex_reg_write), 32'(e.rw));
        check({tag, " ex_mem_read"}, 32'(bus.ex_mem_read), 32'(e.mr));
        check({tag, " ex_mem_write"}, 32'(bus.ex_mem_write), 32'(e.mw));
        check({tag, " ex_mem_to_reg"}, 32'(bus.ex_mem_to_reg), 32'(e.m2r));
        if (e.valid) begin
            check({tag, " ex_fwd_sel_1"}, 32'(bus.ex_fwd_sel_1), 32'(e.s1));
            check({tag, " ex_fwd_sel_2"}, 32'(bus.ex_fwd_sel_2), 32'(e.s2));
            check({tag, " ex_store_fwd_sel"}, 32'(bus.ex_store_fwd_sel),
                  32'(e.st));
            check({tag, " ex_rs1_data"}, bus.ex_rs1_data, e.d1);
            check({tag, " ex_rs2_data"}, bus.ex_rs2_data, e.d2);
            check({tag, " ex_immediate"}, bus.ex_immediate, e.imm);
            check({tag, " ex_alu_operation"}, 32'(bus.ex_alu_operation),
                  32'(e.op));
        end
    endtask

    // Random-phase model: inflight[0] is the instruction in EX,
    // inflight[1] the one in MEM (bubbles included).
    exp_t inflight[$];

    function automatic bit [1:0] youngest_writer(bit [4:0] rs);
        if (rs == 5'd0) return 2'd0;
        for (int age = 0; age < 2; age++) begin
            if (inflight[age].rw && inflight[age].rd == rs)
                return (age == 0) ? 2'd2 : 2'd1;
        end
        return 2'd0;
    endfunction

    function automatic ins_t rand_ins();
        ins_t i;
        int kind;
        i = '0;
        i.v = ($urandom % 8) != 0;
        i.rs1 = 5'($urandom % 8);
        i.rs2 = 5'($urandom % 8);
        i.rd = 5'($urandom % 8);
        i.d1 = $urandom;
        i.d2 = $urandom;
        i.imm = $urandom;
        i.op = 4'($urandom);
        kind = int'($urandom % 5);
        case (kind)
            0: i.rw = 1'b1;
            1: begin i.rw = 1'b1; i.simm = 1'b1; end
            2: begin i.rw = 1'b1; i.mr = 1'b1; i.m2r = 1'b1; i.simm = 1'b1; end
            3: begin i.mw = 1'b1; i.simm = 1'b1; end
            default: begin i.rw = 1'b1; i.z = 1'b1; i.simm = 1'b1; end
        endcase
        return i;
    endfunction

    vec_t tbl[10];

    initial begin
        ins_t zero_i;
        ins_t cur;
        exp_t e;
        exp_t bub;
        bit   hold;
        bit   fl;
        bit   hz;
        bit   exp_stall;
        int   sc;
        int   fc;

        zero_i = '0;
        bub = '0;

        // add x3,x1,x2 / sub x4,x3,x5 / addi x6,x3,7 / lw x0 / read x0 /
        // lw x5 / add x7,x5,x2 (stall, then held) / sw x7 / empty slot
        tbl[0] = row(mk(1, 1, 2, 3, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0, 1, 0, 0, 0, 3);
        tbl[1] = row(mk(1, 3, 5, 4, 0, 0, 0, 1, 0, 0, 0), 0, 0, 0, 0, 1, 2, 0, 0, 4);
        tbl[2] = row(mk(1, 3, 0, 6, 7, 1, 0, 1, 0, 0, 0), 3, 1, 0, 0, 1, 1, 3, 0, 6);
        tbl[3] = row(mk(1, 0, 0, 0, 5, 1, 0, 1, 1, 0, 1), 4, 1, 0, 0, 1, 0, 3, 0, 0);
        tbl[4] = row(mk(1, 0, 0, 8, 0, 0, 0, 1, 0, 0, 0), 6, 1, 0, 0, 1, 0, 0, 0, 8);
        tbl[5] = row(mk(1, 1, 0, 5, 0, 1, 0, 1, 1, 0, 1), 0, 1, 0, 0, 1, 0, 3, 0, 5);
        tbl[6] = row(mk(1, 5, 2, 7, 0, 0, 0, 1, 0, 0, 0), 8, 1, 0, 1, 0, 0, 0, 0, 0);
        tbl[7] = row(mk(1, 5, 2, 7, 0, 0, 0, 1, 0, 0, 0), 5, 1, 0, 0, 1, 1, 0, 0, 7);
        tbl[8] = row(mk(1, 9, 7, 0, 4, 1, 0, 0, 0, 1, 0), 0, 0, 0, 0, 1, 0, 3, 2, 0);
        tbl[9] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 7, 1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tbl[i].id.d1 = 32'h1000 + 32'(i);
            tbl[i].id.d2 = 32'h2000 + 32'(i);
            tbl[i].id.op = 4'(i);
        end

        reset = 1'b1;
        drive(zero_i, 0, 0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_ex("reset", bub);
        check("reset stall", 32'(bus.stall), 0);
        check("reset stall_count", bus.stall_count, 0);
        check("reset flush_count", bus.flush_count, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].id, tbl[i].mrd, tbl[i].mrw, tbl[i].fl);
            @(negedge clk);
            check($sformatf("row%0d stall", i), 32'(bus.stall),
                  32'(tbl[i].e_stall));
            @(posedge clk);
            #1;
            if (tbl[i].e_valid)
                e = latched(tbl[i].id, tbl[i].e_s1, tbl[i].e_s2, tbl[i].e_st);
            else
                e = bub;
            e.rd = tbl[i].e_rd;
            check_ex($sformatf("row%0d", i), e);
        end
        check("table stall_count", bus.stall_count, 1);
        check("table flush_count", bus.flush_count, 0);

        // Load-use hazard coinciding with a flush.
        cur = mk(1, 1, 0, 5, 0, 1, 0, 1, 1, 0, 1);
        drive(cur, 0, 0, 0);
        @(posedge clk);
        #1;
        cur = mk(1, 5, 2, 7, 0, 0, 0, 1, 0, 0, 0);
        drive(cur, 0, 0, 1);
        @(negedge clk);
        check("flush+hazard stall", 32'(bus.stall), 0);
        @(posedge clk);
        #1;
        check_ex("flush+hazard", bub);
        check("flush+hazard flush_count", bus.flush_count, 1);
        check("flush+hazard stall_count", bus.stall_count, 1);
        check("flush+hazard state", 32'(dut.state_q), 32'(NORMAL));

        // The same reader after the flush: load now in MEM, no stall.
        drive(cur, 5, 1, 0);
        @(negedge clk);
        check("post-flush stall", 32'(bus.stall), 0);
        @(posedge clk);
        #1;
        check_ex("post-flush", latched(cur, 1, 0, 0));

        // Asynchronous reset while EX holds a real instruction.
        check("pre-reset ex_valid", 32'(bus.ex_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        check_ex("async reset", bub);
        check("async reset ex_fwd_sel_1", 32'(bus.ex_fwd_sel_1), 0);
        check("async reset ex_fwd_sel_2", 32'(bus.ex_fwd_sel_2), 0);
        check("async reset ex_rs1_data", bus.ex_rs1_data, 0);
        check("async reset ex_immediate", bus.ex_immediate, 0);
        check("async reset stall", 32'(bus.stall), 0);
        check("async reset stall_count", bus.stall_count, 0);
        check("async reset flush_count", bus.flush_count, 0);
        check("async reset state", 32'(dut.state_q), 32'(NORMAL));
        drive(zero_i, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Random phase against the in-flight pipeline model.
        inflight.delete();
        inflight.push_back(bub);
        inflight.push_back(bub);
        sc = 0;
        fc = 0;
        hold = 1'b0;
        cur = rand_ins();
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (!hold) cur = rand_ins();
            fl = ($urandom % 6) == 0;
            drive(cur, inflight[1].rd, inflight[1].rw, fl);
            hz = inflight[0].valid && inflight[0].mr && inflight[0].rd != 0
              && cur.v
              && ((!cur.z && inflight[0].rd == cur.rs1)
               || ((!cur.simm || cur.mw) && inflight[0].rd == cur.rs2));
            exp_stall = hz && !fl;
            @(negedge clk);
            check($sformatf("rand%0d stall", cyc), 32'(bus.stall),
                  32'(exp_stall));
            if (fl || exp_stall) begin
                e = bub;
            end else begin
                e = latched(cur,
                            cur.z ? 2'd3 : youngest_writer(cur.rs1),
                            cur.simm ? 2'd3 : youngest_writer(cur.rs2),
                            youngest_writer(cur.rs2));
            end
            if (exp_stall) sc++;
            if (fl) fc++;
            @(posedge clk);
            #1;
            check_ex($sformatf("rand%0d", cyc), e);
            check($sformatf("rand%0d stall_count", cyc), bus.stall_count,
                  32'(sc));
            check($sformatf("rand%0d flush_count", cyc), bus.flush_count,
                  32'(fc));
            inflight.push_front(e);
            void'(inflight.pop_back());
            hold = exp_stall;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between Decode and Execute in the segmented RISC-V core.
- Latches decoded operands and control, then presents them to the ALU encapsulator together with registered operand-select codes.
- Generates the forwarding selects one cycle early, in Decode, so that Execute sees them straight from flops.
- Detects load-use hazards: it stalls PC and IF/ID for one cycle and inserts a bubble into Execute. Branch flush also inserts a bubble.

Parameters:
- data_bits, 32, operand/immediate width
- reg_addr_bits, 5, register index width
- alu_op_bits, 4, ALU operation code width
- count_bits, 32, stall/flush counter width

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high
- id_valid  in  1  Decode holds a real instruction
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  reg_addr_bits each  decoded register indices
- id_rs1_data, id_rs2_data  in  data_bits each  register-file read data (write-through register file)
- id_immediate  in  data_bits  immediate generator output
- id_alu_operation  in  alu_op_bits  ALU op code
- id_alu_src_imm  in  1  operand 2 is the immediate
- id_op1_zero  in  1  operand 1 forced to zero (LUI)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1 each  control bits
- mem_rd_addr  in  reg_addr_bits  rd of instruction currently in EX/MEM register
- mem_reg_write  in  1  reg_write of that instruction
- flush  in  1  taken branch/jump resolved in Execute
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid  out  1  Execute holds a real instruction
- ex_rs1_data, ex_rs2_data, ex_immediate  out  data_bits each  to register_data_1_in / register_data_2_in / immediate_gen
- ex_rd_addr  out  reg_addr_bits  destination index
- ex_alu_operation  out  alu_op_bits  to alu_operation
- ex_fwd_sel_1, ex_fwd_sel_2  out  2 each  to forward_controller_1/2
- ex_store_fwd_sel  out  2  store-data source: 0 register, 1 WB mux, 2 EX/MEM register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1 each  control for later stages
- stall_count, flush_count  out  count_bits each  saturating event counters

Behaviour:
- Reset (asynchronous): every registered output goes to 0, i.e. a bubble with selects 0. Counters go to 0. State is NORMAL.
- Select encoding for the ALU mux: 0 register data, 1 prev_result_from_mux (WB), 2 prev_result_from_reg (EX/MEM), 3 zero on input 1 or immediate on input 2.
- Operand-select priority for rsN in Decode, with rsN != 0:
  - ex_reg_write && ex_rd_addr == rsN -> 2
  - else mem_reg_write && mem_rd_addr == rsN -> 1
  - else 0
- Final ALU select overrides:
  - sel_1 = 3 when id_op1_zero.
  - sel_2 = 3 when id_alu_src_imm.
  - ex_store_fwd_sel always takes the rs2 forwarding result.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd_addr != 0 && id_valid && ex_rd_addr matches a used source. rs1 counts as used unless id_op1_zero; rs2 counts as used if !id_alu_src_imm or id_mem_write.
- FSM states:
  - NORMAL: hazard -> stall = 1, bubble into EX, go to STALLED. Otherwise latch ID.
  - STALLED: stall = 0. Latch the held ID instruction; the load is now in MEM, so its select resolves to 1. Return to NORMAL.
  - A back-to-back hazard is impossible after a bubble; the RTL must still evaluate the hazard in STALLED.
- Bubble: ex_valid and all control bits go to 0 and ex_rd_addr to 0. Data fields are don't-care (hold the previous value to save power).
- Priority per edge: reset > flush > hazard > normal.
  - flush: bubble into EX, state goes to NORMAL, stall = 0 even if a hazard is present.
  - flush_count increments once per flush.
- stall_count increments once per cycle with stall = 1.
- Both counters saturate at all-ones.
- Latency: one cycle from ID inputs to ex_ outputs. No combinational path from id_ inputs to ex_ outputs. stall depends only on current ex_ registers, id_ inputs and flush.

Decomposition:
- Shared package core_pkg holds:
  - fwd_sel_t enum: FWD_REG = 0, FWD_WB = 1, FWD_MEM = 2, FWD_ALT = 3
  - stage_state_t: NORMAL, STALLED
  - BUBBLE constant for the control bundle
- One sub-module, forward_select: combinational rsN comparison returning fwd_sel_t, instantiated twice.

Test Plan:
- Reset mid-run: assert reset with ex_valid = 1 -> all ex_ outputs, stall, counters and state go to 0 immediately, before the next edge.
- add x3,x1,x2 then sub x4,x3,x5 -> second instruction in EX has ex_fwd_sel_1 = 2, ex_fwd_sel_2 = 0.
- Producer two ahead writes x3 (mem_reg_write = 1, mem_rd_addr = 3), then addi x6,x3,7 -> ex_fwd_sel_1 = 1, ex_fwd_sel_2 = 3, ex_immediate = 7.
- lw x5,0(x1) then add x7,x5,x2:
  - stall = 1 for exactly one cycle; next EX is a bubble (ex_valid = 0).
  - Then add enters with ex_fwd_sel_1 = 1.
  - stall_count = 1.
- Load-use hazard and flush in the same cycle -> stall = 0, bubble into EX, flush_count = 1, stall_count unchanged, state NORMAL.
- Writes to x0 (rd = 0, reg_write = 1) followed by a reader of x0 -> selects 0, no stall.
